// File: rtl/dispatch_pkg.sv
// Shared definitions for the pixel dispatch scheduler: FSM state encoding,
// default geometry/worker constants and a one-hot decode helper.
package dispatch_pkg;

    localparam int DEF_NUM_X_BITS  = 10;
    localparam int DEF_NUM_Y_BITS  = 10;
    localparam int DEF_NUM_WORKERS = 4;
    localparam int MAX_WORKERS     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Decode a worker index into a one-hot vector sized for the largest array.
    function automatic logic [MAX_WORKERS-1:0] onehot(input logic [3:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at or
// after ptr+1 (mod NUM_WORKERS). Pointer and masking state live in the caller.
module rr_arbiter
    import dispatch_pkg::*;
#(
    parameter int NUM_WORKERS = DEF_NUM_WORKERS,
    localparam int PTR_W      = $clog2(NUM_WORKERS)
) (
    input  logic [NUM_WORKERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_WORKERS-1:0] grant,
    output logic [PTR_W-1:0]       grant_idx
);

    logic found;
    int   sum;

    // Scan candidates starting just past the pointer, wrapping at NUM_WORKERS.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        found     = 1'b0;
        grant_idx = '0;
        sum       = 0;
        for (int k = 1; k <= NUM_WORKERS; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_WORKERS) begin
                sum = sum - NUM_WORKERS;
            end
            if (!found && req[PTR_W'(sum)]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(sum);
            end
        end
        grant = found ? NUM_WORKERS'(onehot(4'(grant_idx))) : '0;
    end

endmodule

// File: rtl/pixel_dispatch_sched.sv
// Frame-scan scheduler: walks a frame in raster order (x fastest) and hands
// each coordinate to a ready worker chosen round-robin.
// Optional feature: define DISPATCH_ABORT_EN to add the `abort` input, which
// abandons a running frame (ISSUE or DONE) without a frame_done pulse.
module pixel_dispatch_sched
    import dispatch_pkg::*;
#(
    parameter int NUM_X_BITS  = DEF_NUM_X_BITS,
    parameter int NUM_Y_BITS  = DEF_NUM_Y_BITS,
    parameter int NUM_WORKERS = DEF_NUM_WORKERS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef DISPATCH_ABORT_EN
    input  logic                   abort,
`endif
    input  logic [NUM_X_BITS-1:0]  frame_width,
    input  logic [NUM_Y_BITS-1:0]  frame_height,
    input  logic [NUM_WORKERS-1:0] worker_ready,
    output logic [NUM_WORKERS-1:0] dispatch_valid,
    output logic [NUM_X_BITS-1:0]  pixel_x,
    output logic [NUM_Y_BITS-1:0]  pixel_y,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int               PTR_W   = $clog2(NUM_WORKERS);
    // Pointer parks on the last worker so worker 0 wins the first grant.
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_WORKERS - 1);

    state_e                 state_q;
    logic [NUM_X_BITS-1:0]  width_q;
    logic [NUM_Y_BITS-1:0]  height_q;
    logic [NUM_X_BITS-1:0]  x_q;
    logic [NUM_Y_BITS-1:0]  y_q;
    logic [NUM_X_BITS-1:0]  x_d;
    logic [NUM_Y_BITS-1:0]  y_d;
    logic [PTR_W-1:0]       ptr_q;
    logic [NUM_WORKERS-1:0] dispatch_valid_q;
    logic [NUM_X_BITS-1:0]  pixel_x_q;
    logic [NUM_Y_BITS-1:0]  pixel_y_q;
    logic                   frame_done_q;

    logic [NUM_WORKERS-1:0] eligible;
    logic [NUM_WORKERS-1:0] grant;
    logic [PTR_W-1:0]       grant_idx;
    logic                   any_grant;
    logic                   last_x;
    logic                   last_y;
    logic                   abort_req;

`ifdef DISPATCH_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The worker granted last cycle is exactly the one whose valid is high now;
    // it cannot have dropped ready in time, so it is excluded this cycle.
    assign eligible  = worker_ready & ~dispatch_valid_q;
    assign any_grant = |grant;

    rr_arbiter #(
        .NUM_WORKERS (NUM_WORKERS)
    ) u_arb (
        .req       (eligible),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Raster advance: x fastest, carry into y at the end of a row.
    always_comb begin
        last_x = (x_q == width_q - 1'b1);
        last_y = (y_q == height_q - 1'b1);
        x_d    = last_x ? '0 : x_q + 1'b1;
        y_d    = last_x ? y_q + 1'b1 : y_q;
    end

    // Scheduler FSM with registered dispatch, coordinate and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            width_q          <= '0;
            height_q         <= '0;
            x_q              <= '0;
            y_q              <= '0;
            ptr_q            <= PTR_RST;
            dispatch_valid_q <= '0;
            pixel_x_q        <= '0;
            pixel_y_q        <= '0;
            frame_done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
            dispatch_valid_q <= '0;
            frame_done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // frame_done_q high means the previous frame is still reporting busy.
                    if (start && !frame_done_q && !abort_req) begin
                        width_q  <= frame_width;
                        height_q <= frame_height;
                        x_q      <= '0;
                        y_q      <= '0;
                        ptr_q    <= PTR_RST;
                        state_q  <= (frame_width == '0 || frame_height == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort_req) begin
                        state_q <= ST_IDLE;
                    end else if (any_grant) begin
                        dispatch_valid_q <= grant;
                        pixel_x_q        <= x_q;
                        pixel_y_q        <= y_q;
                        ptr_q            <= grant_idx;
                        x_q              <= x_d;
                        y_q              <= y_d;
                        if (last_x && last_y) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    frame_done_q <= !abort_req;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dispatch_valid = dispatch_valid_q;
    assign pixel_x        = pixel_x_q;
    assign pixel_y        = pixel_y_q;
    assign frame_done     = frame_done_q;
    // Busy covers the frame_done cycle, when the FSM has already returned to IDLE.
    assign busy           = (state_q != ST_IDLE) || frame_done_q;

endmodule

// File: tb/tb_pixel_dispatch_sched.sv
// Self-checking bench for pixel_dispatch_sched. A behavioural model keeps the
// remaining pixels of the frame in a queue and picks workers by the
// round-robin rule; DUT outputs are compared every cycle, #1 after the edge.
module tb_pixel_dispatch_sched;

    localparam int NX = 10;
    localparam int NY = 10;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort_r;
    logic [NX-1:0] fw;
    logic [NY-1:0] fh;
    logic [NW-1:0] ready;
    logic [NW-1:0] dv;
    logic [NX-1:0] px;
    logic [NY-1:0] py;
    logic          busy;
    logic          fdone;

    always #5 clk = ~clk;

    pixel_dispatch_sched #(
        .NUM_X_BITS  (NX),
        .NUM_Y_BITS  (NY),
        .NUM_WORKERS (NW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
`ifdef DISPATCH_ABORT_EN
        .abort          (abort_r),
`endif
        .frame_width    (fw),
        .frame_height   (fh),
        .worker_ready   (ready),
        .dispatch_valid (dv),
        .pixel_x        (px),
        .pixel_y        (py),
        .busy           (busy),
        .frame_done     (fdone)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int dut_disp;

    // Model: 0 idle, 1 scanning, 2 last pixel out, 3 frame_done showing.
    int m_phase;
    int m_ptr;
    int m_grant;      // worker whose valid is expected now, -1 for none
    int m_x;
    int m_y;
    bit m_done;
    int qx[$];
    int qy[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_tick();
        int nxt_grant;
        bit nxt_done;
        int idx;
        nxt_grant = -1;
        nxt_done  = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_ptr   = NW - 1;
            m_grant = -1;
            m_x     = 0;
            m_y     = 0;
            m_done  = 1'b0;
            qx.delete();
            qy.delete();
            return;
        end
        case (m_phase)
            0: begin
                if (start && !abort_r) begin
                    qx.delete();
                    qy.delete();
                    for (int y = 0; y < int'(fh); y++)
                        for (int x = 0; x < int'(fw); x++) begin
                            qx.push_back(x);
                            qy.push_back(y);
                        end
                    m_ptr   = NW - 1;
                    m_phase = (qx.size() == 0) ? 2 : 1;
                end
            end
            1: begin
                if (abort_r) begin
                    m_phase = 0;
                end else begin
                    for (int k = 0; k < NW; k++) begin
                        idx = (m_ptr + 1 + k) % NW;
                        if (nxt_grant < 0 && ((ready >> idx) & 1) != 0 && idx != m_grant)
                            nxt_grant = idx;
                    end
                    if (nxt_grant >= 0) begin
                        m_x   = qx.pop_front();
                        m_y   = qy.pop_front();
                        m_ptr = nxt_grant;
                        if (qx.size() == 0) m_phase = 2;
                    end
                end
            end
            2: begin
                nxt_done = !abort_r;
                m_phase  = nxt_done ? 3 : 0;
            end
            default: m_phase = 0;
        endcase
        m_grant = nxt_grant;
        m_done  = nxt_done;
    endtask

    task automatic cycle();
        logic [NW-1:0] e;
        bit was_rst;
        was_rst = rst;
        model_tick();
        @(posedge clk);
        #1;
        e = (m_grant >= 0) ? (NW'(1) << m_grant) : '0;
        chk("dispatch_valid", 32'(dv), 32'(e));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("frame_done", 32'(fdone), 32'(m_done));
        if (m_grant >= 0) begin
            chk("pixel_x", 32'(px), 32'(m_x));
            chk("pixel_y", 32'(py), 32'(m_y));
        end
        if (was_rst) begin
            chk("rst_pixel_x", 32'(px), 32'd0);
            chk("rst_pixel_y", 32'(py), 32'd0);
        end
        if (|dv) dut_disp++;
    endtask

    // 0: all ready, 1: random, 2: only w1, dropping ready while its valid is up.
    function automatic logic [NW-1:0] ready_for(input int mode);
        case (mode)
            0:       return '1;
            1:       return NW'($urandom);
            2:       return (m_grant == 1) ? '0 : NW'(2);
            default: return '0;
        endcase
    endfunction

    task automatic run_frame(input int w, input int h, input int mode, input int stall_at,
                             input int stall_len, input bit hold_start, output int done_lat);
        int n;
        dut_disp = 0;
        done_lat = -1;
        fw       = NX'(w);
        fh       = NY'(h);
        start    = 1'b1;
        ready    = ready_for(mode);
        cycle();
        start = hold_start;
        fw    = NX'($urandom);
        fh    = NY'($urandom);
        n     = 1;
        while (m_phase != 0 && n < 3000) begin
            if (n >= stall_at && n < stall_at + stall_len) ready = '0;
            else ready = ready_for(mode);
            cycle();
            n++;
            if (fdone && done_lat < 0) done_lat = n;
        end
        start = 1'b0;
        chk("frame_completes", 32'(busy), 32'd0);
        chk("dispatch_count", 32'(dut_disp), 32'(w * h));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        abort_r = 1'b0;
        fw      = '0;
        fh      = '0;
        ready   = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // 2x2, everyone ready: rotation skips only the previously granted worker.
        run_frame(2, 2, 0, 0, 0, 1'b0, lat);
        cycle();

        // 3x1, only w1 ready and toggling: one pixel every other cycle.
        run_frame(3, 1, 2, 0, 0, 1'b0, lat);

        // 4x4 with a 5-cycle stall mid-scan.
        run_frame(4, 4, 1, 4, 5, 1'b0, lat);

        // Zero-width frame with start held through busy.
        run_frame(0, 5, 0, 0, 0, 1'b1, lat);
        chk("zero_frame_done_latency", 32'(lat), 32'd2);
        cycle();

        // 8x8 interrupted by reset on the third dispatch, then restarted.
        dut_disp = 0;
        fw       = NX'(8);
        fh       = NY'(8);
        start    = 1'b1;
        ready    = '1;
        cycle();
        start = 1'b0;
        n     = 0;
        while (dut_disp < 3 && n < 40) begin
            cycle();
            n++;
        end
        chk("third_dispatch_seen", 32'(dut_disp), 32'd3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        run_frame(8, 8, 1, 0, 0, 1'b0, lat);

        // Random frames under random readiness.
        repeat (6) begin
            run_frame($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 1),
                      0, 0, 1'b0, lat);
            cycle();
        end

`ifdef DISPATCH_ABORT_EN
        // Abort while the fifth pixel is being granted.
        dut_disp = 0;
        fw       = NX'(4);
        fh       = NY'(4);
        start    = 1'b1;
        ready    = '1;
        cycle();
        start = 1'b0;
        n     = 0;
        while (dut_disp < 4 && n < 40) begin
            cycle();
            n++;
        end
        chk("fourth_dispatch_seen", 32'(dut_disp), 32'd4);
        abort_r = 1'b1;
        cycle();
        chk("abort_no_valid", 32'(dv), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        abort_r = 1'b0;
        repeat (3) cycle();
        // Abort in IDLE blocks a simultaneous start.
        abort_r = 1'b1;
        start   = 1'b1;
        fw      = NX'(2);
        fh      = NY'(2);
        cycle();
        abort_r = 1'b0;
        start   = 1'b0;
        cycle();
        run_frame(3, 2, 1, 0, 0, 1'b0, lat);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
